// File: rtl/axil_master_cmd.sv
// AXI4-Lite initiator: one user register command in, one AXI4-Lite transaction out, one response back.
// Optional watchdog recovery when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_master_cmd #(
   parameter int ADDR_WIDTH     = 5,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic                    aclk,
   input  logic                    aresetn,
   // user command channel
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
   // user response channel
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_write,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [1:0]              resp_resp,
   output logic                    resp_timeout,
   // AXI4-Lite write address
   output logic [ADDR_WIDTH-1:0]   awaddr,
   output logic [2:0]              awprot,
   output logic                    awvalid,
   input  logic                    awready,
   // AXI4-Lite write data
   output logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wvalid,
   input  logic                    wready,
   // AXI4-Lite write response
   input  logic [1:0]              bresp,
   input  logic                    bvalid,
   output logic                    bready,
   // AXI4-Lite read address
   output logic [ADDR_WIDTH-1:0]   araddr,
   output logic [2:0]              arprot,
   output logic                    arvalid,
   input  logic                    arready,
   // AXI4-Lite read data
   input  logic [DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]              rresp,
   input  logic                    rvalid,
   output logic                    rready
);

   typedef enum logic [2:0] {IDLE, WR, WR_B, RD_A, RD_D, RESP} state_t;
   state_t state;

   if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_err
      $error("axil_master_cmd: only DATA_WIDTH=32 and TIMEOUT_CYCLES>=1 are supported");
   end

   assign awprot = 3'b000;
   assign arprot = 3'b000;

   // A channel counts as done once its valid has dropped or is handshaking now.
   logic aw_done, w_done;
   assign aw_done = !awvalid || awready;
   assign w_done  = !wvalid  || wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
   logic [31:0] tmo_cnt;
   logic        busy;
   assign busy = (state == WR) || (state == WR_B) || (state == RD_A) || (state == RD_D);
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state        <= IDLE;
         cmd_ready    <= 1'b1;
         awaddr       <= '0;
         awvalid      <= 1'b0;
         wdata        <= '0;
         wstrb        <= '0;
         wvalid       <= 1'b0;
         bready       <= 1'b0;
         araddr       <= '0;
         arvalid      <= 1'b0;
         rready       <= 1'b0;
         resp_valid   <= 1'b0;
         resp_write   <= 1'b0;
         resp_rdata   <= '0;
         resp_resp    <= 2'b00;
         resp_timeout <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_ready  <= 1'b0;
                  resp_write <= cmd_write;
`ifdef AXIL_MASTER_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
                  if (cmd_write) begin
                     awaddr  <= cmd_addr;
                     wdata   <= cmd_wdata;
                     wstrb   <= cmd_wstrb;
                     awvalid <= 1'b1;
                     wvalid  <= 1'b1;
                     state   <= WR;
                  end else begin
                     araddr  <= cmd_addr;
                     arvalid <= 1'b1;
                     state   <= RD_A;
                  end
               end
            end
            WR: begin
               if (awready) awvalid <= 1'b0;
               if (wready)  wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  bready <= 1'b1;
                  state  <= WR_B;
               end
            end
            WR_B: begin
               if (bvalid) begin
                  bready     <= 1'b0;
                  resp_resp  <= bresp;
                  resp_rdata <= '0;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RD_A: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= RD_D;
               end
            end
            RD_D: begin
               if (rvalid) begin
                  rready     <= 1'b0;
                  resp_rdata <= rdata;
                  resp_resp  <= rresp;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid   <= 1'b0;
                  resp_timeout <= 1'b0;
                  cmd_ready    <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
         // Watchdog wins over any handshake in the same cycle and abandons the bus.
         if (busy) begin
            tmo_cnt <= tmo_cnt + 32'd1;
            if (tmo_cnt == TMO_LAST) begin
               awvalid      <= 1'b0;
               wvalid       <= 1'b0;
               bready       <= 1'b0;
               arvalid      <= 1'b0;
               rready       <= 1'b0;
               resp_valid   <= 1'b1;
               resp_resp    <= 2'b10;
               resp_rdata   <= '0;
               resp_timeout <= 1'b1;
               state        <= RESP;
            end
         end
`endif
      end
   end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Bench for axil_master_cmd: randomized AXI4-Lite slave plus a command-level register model.
module tb_axil_master_cmd;
   localparam int AW = 5;
   localparam int TMO = 16;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
   logic [4:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic [3:0]  cmd_wstrb = '0;
   logic        resp_valid, resp_ready = 0, resp_write, resp_timeout;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_resp;
   logic [4:0]  awaddr, araddr;
   logic [2:0]  awprot, arprot;
   logic        awvalid, awready = 0, wvalid, wready = 0, bvalid = 0, bready;
   logic        arvalid, arready = 0, rvalid = 0, rready;
   logic [31:0] wdata, rdata = '0;
   logic [3:0]  wstrb;
   logic [1:0]  bresp = '0, rresp = '0;

   axil_master_cmd #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
      .resp_rdata(resp_rdata), .resp_resp(resp_resp), .resp_timeout(resp_timeout),
      .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0, n_viol = 0, n_rsp_hs = 0, exp_rsp = 0, n_bhs = 0, n_wr = 0;
   int last_hs = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: register file seen at command level; slave flags SLVERR for word 7.
   logic [31:0] ref_mem [8];
   function automatic logic [1:0] exp_code(input logic [4:0] a);
      return (a[4:2] == 3'd7) ? 2'b10 : 2'b00;
   endfunction

   // ---------------- AXI4-Lite slave ----------------
   logic [31:0] s_mem [8];
   bit rnd_mode = 0, b_never = 0, s_flush = 0;
   int aw_delay = 0, r_wait = -1;
   bit aw_hs, w_hs, ar_hs, aw_have, w_have, ar_have, b_armed, r_armed;
   int aw_cnt, b_cnt, r_cnt;
   logic [4:0]  s_awaddr, s_araddr;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;

   function automatic bit rdy_pick();
      return rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
   endfunction
   function automatic int wait_pick();
      return rnd_mode ? int'($urandom_range(0, 3)) : 0;
   endfunction

   initial begin
      forever begin
         @(negedge aclk);
         if (!aresetn || s_flush) begin
            {aw_hs, w_hs, ar_hs, aw_have, w_have, ar_have, b_armed, r_armed} = '0;
            aw_cnt = 0; s_flush = 0;
            {awready, wready, bvalid, arready, rvalid} = '0;
            continue;
         end
         if (aw_hs) begin aw_have = 1; aw_hs = 0; end
         if (w_hs)  begin w_have = 1;  w_hs = 0;  end
         if (ar_hs) begin ar_have = 1; ar_hs = 0; end
         awready = 0;
         if (awvalid && !aw_have) begin
            if (aw_cnt < aw_delay) aw_cnt++;
            else if (rdy_pick()) begin awready = 1; aw_hs = 1; s_awaddr = awaddr; aw_cnt = 0; end
         end
         wready = 0;
         if (wvalid && !w_have && rdy_pick()) begin
            wready = 1; w_hs = 1; s_wdata = wdata; s_wstrb = wstrb;
         end
         bvalid = 0;
         if (aw_have && w_have && !b_never) begin
            if (!b_armed) begin b_armed = 1; b_cnt = wait_pick(); end
            if (b_cnt > 0) b_cnt--;
            else begin
               bvalid = 1;
               bresp = exp_code(s_awaddr);
               if (bready) begin
                  if (bresp == 2'b00)
                     for (int i = 0; i < 4; i++)
                        if (s_wstrb[i]) s_mem[s_awaddr[4:2]][8*i +: 8] = s_wdata[8*i +: 8];
                  aw_have = 0; w_have = 0; b_armed = 0; n_bhs++;
               end
            end
         end
         arready = 0;
         if (arvalid && !ar_have && rdy_pick()) begin
            arready = 1; ar_hs = 1; s_araddr = araddr;
         end
         rvalid = 0;
         if (ar_have) begin
            if (!r_armed) begin r_armed = 1; r_cnt = (r_wait >= 0) ? r_wait : wait_pick(); end
            if (r_cnt > 0) r_cnt--;
            else begin
               rvalid = 1; rdata = s_mem[s_araddr[4:2]]; rresp = exp_code(s_araddr);
               if (rready) begin ar_have = 0; r_armed = 0; end
            end
         end
      end
   end

   // ---------------- protocol monitor ----------------
   task automatic note_viol(input string s);
      n_viol++;
      if (n_viol <= 5) $display("protocol: %s at cycle %0d", s, cyc);
   endtask

   initial begin
      logic p_rst, p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_rv, p_rr;
      logic [4:0]  p_awaddr, p_araddr;
      logic [35:0] p_w;
      logic [35:0] p_pay;
      p_rst = 0;
      forever begin
         @(negedge aclk); #1;
         if (aresetn && p_rst) begin
            if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) note_viol("aw hold");
            if (p_wv && !p_wr && (!wvalid || {wstrb, wdata} !== p_w)) note_viol("w hold");
            if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) note_viol("ar hold");
            if (p_rv && !p_rr && (!resp_valid || {resp_write, resp_timeout, resp_resp, resp_rdata} !== p_pay))
               note_viol("resp hold");
         end
         if ((awvalid || wvalid || bready) && (arvalid || rready)) note_viol("rd/wr overlap");
         if (cmd_ready && (awvalid || wvalid || bready || arvalid || rready || resp_valid)) note_viol("cmd_ready busy");
         if (awprot !== 3'b000 || arprot !== 3'b000) note_viol("prot");
         if (aresetn && resp_valid && resp_ready) n_rsp_hs++;
         p_rst = aresetn; p_awv = awvalid; p_awr = awready; p_wv = wvalid; p_wr = wready;
         p_arv = arvalid; p_arr = arready; p_rv = resp_valid; p_rr = resp_ready;
         p_awaddr = awaddr; p_araddr = araddr; p_w = {wstrb, wdata};
         p_pay = {resp_write, resp_timeout, resp_resp, resp_rdata};
      end
   end

   // Issue one command (called just after a negedge) and check its response.
   task automatic run_cmd(input bit wr, input logic [4:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                          input int hold, input bit keep, input int exp_lat, input int exp_acc);
      int a, t;
      logic [31:0] er;
      logic [1:0]  ec;
      ec = exp_code(addr);
      er = wr ? 32'd0 : ref_mem[addr[4:2]];
      cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
      t = 0;
      while (!cmd_ready && t < 200) begin @(negedge aclk); t++; end
      chk("cmd_accept", cmd_ready, 1);
      a = cyc;
      if (exp_acc >= 0) chk("b2b_accept_cycle", a, exp_acc);
      exp_rsp++;
      if (wr) n_wr++;
      if (wr && ec == 2'b00)
         for (int i = 0; i < 4; i++) if (ws[i]) ref_mem[addr[4:2]][8*i +: 8] = wd[8*i +: 8];
      @(negedge aclk);
      if (!keep) cmd_valid = 0;
      t = 0;
      while (!resp_valid && t < 300) begin @(negedge aclk); t++; end
      chk("resp_valid", resp_valid, 1);
      if (exp_lat >= 0) chk("resp_latency", cyc - a, exp_lat);
      chk("resp_write", resp_write, wr);
      chk("resp_rdata", resp_rdata, er);
      chk("resp_resp", resp_resp, ec);
      chk("resp_timeout", resp_timeout, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge aclk);
         chk("hold_cmd_ready", cmd_ready, 0);
         chk("hold_valid", resp_valid, 1);
         chk("hold_payload", {resp_write, resp_resp, resp_rdata[28:0]}, {wr, ec, er[28:0]});
      end
      resp_ready = 1;
      last_hs = cyc;
      @(negedge aclk);
      resp_ready = 0;
   endtask

   initial begin
      int t, a;
      #500000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      int t, a;
      for (int i = 0; i < 8; i++) begin s_mem[i] = '0; ref_mem[i] = '0; end
      s_mem[1] = 32'hDEAD_BEEF; ref_mem[1] = 32'hDEAD_BEEF;
      aresetn = 1;
      #1 aresetn = 0;
      #1;
      chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_timeout}, 0);
      chk("rst_addr", {awaddr, araddr, awprot, arprot}, 0);
      chk("rst_wdata", {wstrb, wdata[27:0]}, 0);
      chk("rst_resp", {resp_write, resp_resp, resp_rdata[28:0]}, 0);
      repeat (3) @(negedge aclk);
      aresetn = 1;
      @(negedge aclk);
      chk("idle_cmd_ready", cmd_ready, 1);

      // zero-wait write, timing of valids and response
      fork
         run_cmd(1, 5'h08, 32'h0000_1234, 4'hF, 0, 0, 3, -1);
         begin
            @(negedge aclk);
            chk("wr_c1_valids", {awvalid, wvalid}, 2'b11);
            chk("wr_c1_awaddr", awaddr, 5'h08);
            chk("wr_c1_wdata", wdata, 32'h1234);
         end
      join
      run_cmd(0, 5'h08, 0, 0, 0, 0, 3, -1);

      // read with 5 wait cycles on rvalid
      r_wait = 5;
      run_cmd(0, 5'h04, 0, 0, 0, 0, -1, -1);
      r_wait = -1;

      // awready delayed behind wready
      aw_delay = 3;
      fork
         run_cmd(1, 5'h0C, 32'hCAFE_F00D, 4'h3, 0, 0, -1, -1);
         begin
            repeat (2) @(negedge aclk);
            chk("split_wvalid_dropped", wvalid, 0);
            chk("split_awvalid_held", awvalid, 1);
            chk("split_awaddr", awaddr, 5'h0C);
         end
      join
      aw_delay = 0;
      run_cmd(0, 5'h0C, 0, 0, 0, 0, -1, -1);

      // SLVERR read with response back-pressure
      run_cmd(0, 5'h1C, 0, 0, 4, 0, -1, -1);

      // back-to-back with cmd_valid held
      run_cmd(1, 5'h10, 32'h1357_9BDF, 4'hF, 0, 1, -1, -1);
      run_cmd(0, 5'h10, 0, 0, 0, 0, -1, last_hs + 1);

      // reset during WR_B abandons the write
      b_never = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h14; cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'hF;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
      @(negedge aclk);
      cmd_valid = 0;
      t = 0;
      while (!bready && t < 50) begin @(negedge aclk); t++; end
      chk("rst_mid_bready", bready, 1);
      #2 aresetn = 0;
      #1;
      chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready, resp_valid, resp_timeout}, 0);
      chk("rst_mid_data", {awaddr, wstrb, wdata[22:0]}, 0);
      @(negedge aclk);
      #2 aresetn = 1;
      b_never = 0;
      @(negedge aclk);
      chk("rst_mid_idle", {cmd_ready, resp_valid}, 2'b10);
      run_cmd(0, 5'h14, 0, 0, 0, 0, -1, -1);

`ifdef AXIL_MASTER_TIMEOUT_EN
      // hung slave: watchdog returns a timeout response
      b_never = 1;
      cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h00; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
      t = 0;
      while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
      a = cyc;
      @(negedge aclk);
      cmd_valid = 0;
      t = 0;
      while (!resp_valid && t < 200) begin @(negedge aclk); t++; end
      chk("tmo_latency", cyc - a, TMO + 1);
      chk("tmo_flag", resp_timeout, 1);
      chk("tmo_resp", resp_resp, 2'b10);
      chk("tmo_rdata", resp_rdata, 0);
      chk("tmo_bus_idle", {awvalid, wvalid, bready, arvalid, rready}, 0);
      exp_rsp++;
      resp_ready = 1;
      @(negedge aclk);
      resp_ready = 0;
      chk("tmo_flag_cleared", resp_timeout, 0);
      b_never = 0; s_flush = 1;
      @(negedge aclk);
`endif

      // randomized traffic against the register model
      rnd_mode = 1;
      for (int k = 0; k < 40; k++) begin
         logic [4:0] ra;
         ra = 5'($urandom_range(0, 7) << 2);
         run_cmd(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)), 0, -1, -1);
      end
      rnd_mode = 0;
      repeat (3) @(negedge aclk);

      chk("protocol_violations", n_viol, 0);
      chk("response_count", n_rsp_hs, exp_rsp);
      chk("write_resp_count", n_bhs, n_wr);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
